// File: rtl/jtag_dma_pkg.sv
// rtl/jtag_dma_pkg.sv - shared FSM encoding and constants for the JTAG DMA engine
package jtag_dma_pkg;

    localparam int   BUS_TIMEOUT_DEFAULT = 255;
    localparam logic DIR_WRITE           = 1'b0;
    localparam logic DIR_READ            = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_W_FETCH,
        S_W_DRIVE,
        S_R_WAIT,
        S_END,
        S_ABORT
    } dma_state_t;

    // States in which the engine owns the bus and a bus error aborts it.
    function automatic logic is_bus_phase(input dma_state_t s);
        return (s == S_BEGIN) || (s == S_W_FETCH) || (s == S_W_DRIVE) || (s == S_R_WAIT);
    endfunction

endpackage

// File: rtl/dma_timeout_counter.sv
// rtl/dma_timeout_counter.sv - reloadable down-counter that flags a stalled bus transaction
module dma_timeout_counter #(
    parameter int LOAD_VALUE = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(LOAD_VALUE + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_load) begin
            r_count <= W'(LOAD_VALUE);
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == '0);

endmodule

// File: rtl/jtag_dma_engine.sv
// rtl/jtag_dma_engine.sv - bus master executing JTAG chain-1 write/read bursts via the ping-pong buffer
module jtag_dma_engine
    import jtag_dma_pkg::*;
#(
    parameter int BUF_ADDR_W  = 9,
    parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           dma_address,
    input  logic [3:0]            dma_byte_enable,
    input  logic [7:0]            dma_burst_size,
    input  logic                  dma_data_ready,
    input  logic                  dma_readReady,
    output logic                  switch_ready,
    output logic                  dma_busy,
    output logic                  dma_error,
    output logic [BUF_ADDR_W-1:0] buf_address,
    output logic                  buf_writeEnable,
    output logic [31:0]           buf_dataIn,
    input  logic [31:0]           buf_dataOut,
    output logic                  request_transaction,
    input  logic                  transaction_granted,
    output logic                  begin_transaction_out,
    output logic [31:0]           address_data_out,
    output logic [3:0]            byte_enables_out,
    output logic [7:0]            burst_size_out,
    output logic                  read_n_write_out,
    output logic                  data_valid_out,
    output logic                  end_transaction_out,
    input  logic [31:0]           address_data_in,
    input  logic                  data_valid_in,
    input  logic                  busy_in,
    input  logic                  end_transaction_in,
    input  logic                  error_in
);

    dma_state_t  r_state;
    dma_state_t  w_next;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [7:0]  r_burst;
    logic        r_dir;
    logic [7:0]  r_cnt;
    logic        r_full;
    logic        r_error;
    logic [31:0] r_wdata;
    logic        r_prev_fetch;

    logic        w_launch;
    logic        w_progress;
    logic        w_expired;
    logic        w_abort;
    logic        w_rd_write;
    logic        w_last_beat;
    logic [31:0] w_wdata;

    assign w_launch    = (r_state == S_IDLE) && (dma_data_ready || dma_readReady);
    assign w_progress  = transaction_granted || data_valid_in || !busy_in;
    assign w_last_beat = (r_cnt == r_burst);
    assign w_rd_write  = (r_state == S_R_WAIT) && data_valid_in && !r_full;
    // Buffer data arrives the cycle after W_FETCH; later stall cycles replay the held copy.
    assign w_wdata     = r_prev_fetch ? buf_dataOut : r_wdata;
    assign w_abort     = (is_bus_phase(r_state) && error_in) ||
                         (((r_state == S_REQUEST) || is_bus_phase(r_state)) && w_expired);

    dma_timeout_counter #(
        .LOAD_VALUE(BUS_TIMEOUT)
    ) u_timeout (
        .i_clk    (clock),
        .i_reset  (reset),
        .i_load   ((r_state == S_IDLE) || w_progress),
        .i_enable (r_state != S_IDLE),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_launch) w_next = S_REQUEST;
            S_REQUEST: if (transaction_granted) w_next = S_BEGIN;
            S_BEGIN:   w_next = (r_dir == DIR_READ) ? S_R_WAIT : S_W_FETCH;
            S_W_FETCH: w_next = S_W_DRIVE;
            S_W_DRIVE: if (!busy_in) w_next = w_last_beat ? S_END : S_W_FETCH;
            S_R_WAIT:  if (end_transaction_in) w_next = S_IDLE;
            S_END:     w_next = S_IDLE;
            S_ABORT:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_ABORT;
        end
    end

    always_comb begin
        switch_ready          = 1'b0;
        request_transaction   = 1'b0;
        begin_transaction_out = 1'b0;
        address_data_out      = '0;
        byte_enables_out      = '0;
        burst_size_out        = '0;
        read_n_write_out      = 1'b0;
        data_valid_out        = 1'b0;
        end_transaction_out   = 1'b0;
        buf_address           = '0;
        buf_writeEnable       = 1'b0;
        buf_dataIn            = '0;
        case (r_state)
            S_IDLE:    switch_ready = 1'b1;
            S_REQUEST: request_transaction = 1'b1;
            S_BEGIN: begin
                begin_transaction_out = 1'b1;
                address_data_out      = r_addr;
                byte_enables_out      = r_be;
                burst_size_out        = r_burst;
                read_n_write_out      = r_dir;
            end
            S_W_FETCH: buf_address = BUF_ADDR_W'(r_cnt);
            S_W_DRIVE: begin
                data_valid_out   = 1'b1;
                address_data_out = w_wdata;
            end
            S_R_WAIT: begin
                buf_address     = BUF_ADDR_W'(r_cnt);
                buf_writeEnable = w_rd_write;
                buf_dataIn      = w_rd_write ? address_data_in : '0;
            end
            S_END:     end_transaction_out = 1'b1;
            S_ABORT:   end_transaction_out = 1'b1;
            default:   ;
        endcase
    end

    assign dma_busy  = (r_state != S_IDLE);
    assign dma_error = r_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr       <= '0;
            r_be         <= '0;
            r_burst      <= '0;
            r_dir        <= DIR_WRITE;
            r_cnt        <= '0;
            r_full       <= 1'b0;
            r_error      <= 1'b0;
            r_wdata      <= '0;
            r_prev_fetch <= 1'b0;
        end else begin
            r_prev_fetch <= (r_state == S_W_FETCH);
            if (w_launch) begin
                r_addr  <= dma_address;
                r_be    <= dma_byte_enable;
                r_burst <= dma_burst_size;
                r_dir   <= dma_data_ready ? DIR_WRITE : DIR_READ;
                r_cnt   <= '0;
                r_full  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_next == S_ABORT) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_W_DRIVE) && r_prev_fetch) begin
                r_wdata <= buf_dataOut;
            end
            if ((r_state == S_W_DRIVE) && (w_next == S_W_FETCH)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Once the last expected word lands, surplus read beats are dropped.
            if (w_rd_write) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_last_beat) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_dma_engine.sv
// tb/tb_jtag_dma_engine.sv - self-checking bench for jtag_dma_engine
module tb_jtag_dma_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic [7:0]  dma_burst_size;
    logic        dma_data_ready;
    logic        dma_readReady;
    logic        switch_ready;
    logic        dma_busy;
    logic        dma_error;
    logic [8:0]  buf_address;
    logic        buf_writeEnable;
    logic [31:0] buf_dataIn;
    logic [31:0] buf_dataOut;
    logic        request_transaction;
    logic        transaction_granted;
    logic        begin_transaction_out;
    logic [31:0] address_data_out;
    logic [3:0]  byte_enables_out;
    logic [7:0]  burst_size_out;
    logic        read_n_write_out;
    logic        data_valid_out;
    logic        end_transaction_out;
    logic [31:0] address_data_in;
    logic        data_valid_in;
    logic        busy_in;
    logic        end_transaction_in;
    logic        error_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] src_mem [0:511];

    typedef struct {
        bit          rd;
        bit          both;
        bit          spur;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [7:0]  burst;
        int          gnt_dly;
        int          stall_at;
        int          stall_len;
        int          n_ret;
        logic [31:0] dbase;
        logic [31:0] dstep;
        int          exp_count;
    } vec_t;

    always #5 clock = ~clock;

    always @(posedge clock) buf_dataOut <= src_mem[buf_address];

    jtag_dma_engine #(.BUF_ADDR_W(9), .BUS_TIMEOUT(255)) dut (
        .clock                (clock),
        .reset                (reset),
        .dma_address          (dma_address),
        .dma_byte_enable      (dma_byte_enable),
        .dma_burst_size       (dma_burst_size),
        .dma_data_ready       (dma_data_ready),
        .dma_readReady        (dma_readReady),
        .switch_ready         (switch_ready),
        .dma_busy             (dma_busy),
        .dma_error            (dma_error),
        .buf_address          (buf_address),
        .buf_writeEnable      (buf_writeEnable),
        .buf_dataIn           (buf_dataIn),
        .buf_dataOut          (buf_dataOut),
        .request_transaction  (request_transaction),
        .transaction_granted  (transaction_granted),
        .begin_transaction_out(begin_transaction_out),
        .address_data_out     (address_data_out),
        .byte_enables_out     (byte_enables_out),
        .burst_size_out       (burst_size_out),
        .read_n_write_out     (read_n_write_out),
        .data_valid_out       (data_valid_out),
        .end_transaction_out  (end_transaction_out),
        .address_data_in      (address_data_in),
        .data_valid_in        (data_valid_in),
        .busy_in              (busy_in),
        .end_transaction_in   (end_transaction_in),
        .error_in             (error_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        return v.dbase + v.dstep * 32'(i);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_switch_ready"}, switch_ready, 1);
        chk({tag, "_busy"}, dma_busy, 0);
        chk({tag, "_error"}, dma_error, 0);
        chk({tag, "_buf_addr"}, buf_address, 0);
        chk({tag, "_buf_we"}, buf_writeEnable, 0);
        chk({tag, "_buf_din"}, buf_dataIn, 0);
        chk({tag, "_req"}, request_transaction, 0);
        chk({tag, "_begin"}, begin_transaction_out, 0);
        chk({tag, "_adout"}, address_data_out, 0);
        chk({tag, "_beout"}, byte_enables_out, 0);
        chk({tag, "_bsout"}, burst_size_out, 0);
        chk({tag, "_rnw"}, read_n_write_out, 0);
        chk({tag, "_dvo"}, data_valid_out, 0);
        chk({tag, "_eto"}, end_transaction_out, 0);
    endtask

    task automatic launch(input logic [31:0] addr, input logic [7:0] burst, input bit wr, input bit rd);
        @(negedge clock);
        dma_address     = addr;
        dma_byte_enable = 4'hF;
        dma_burst_size  = burst;
        dma_data_ready  = wr;
        dma_readReady   = rd;
        @(negedge clock);
        dma_data_ready  = 1'b0;
        dma_readReady   = 1'b0;
    endtask

    task automatic wait_grant_until_drive(input string tag, input bit want_begin);
        int n;
        n = 0;
        while (!(want_begin ? begin_transaction_out : data_valid_out) && n < 50) begin
            transaction_granted = request_transaction;
            @(negedge clock);
            n++;
        end
        transaction_granted = 1'b0;
        chk({tag, "_reached"}, n < 50, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int req_n, beat, stall_n, ret_n, wr_n, cyc;
        bit begun, end_sent, ended, spur_done, is_rd;
        is_rd = v.rd && !v.both;
        req_n = 0; beat = 0; stall_n = 0; ret_n = 0; wr_n = 0;
        begun = 0; end_sent = 0; ended = 0; spur_done = 0;
        if (!is_rd) for (int i = 0; i <= int'(v.burst); i++) src_mem[i] = word_of(v, i);
        @(negedge clock);
        dma_address     = v.addr;
        dma_byte_enable = v.be;
        dma_burst_size  = v.burst;
        dma_data_ready  = !is_rd;
        dma_readReady   = v.rd;
        @(negedge clock);
        dma_data_ready  = 1'b0;
        dma_readReady   = 1'b0;
        chk({tag, "_busy_on_launch"}, dma_busy, 1);
        chk({tag, "_swready_on_launch"}, switch_ready, 0);
        chk({tag, "_error_cleared"}, dma_error, 0);
        for (cyc = 0; cyc < 300; cyc++) begin
            transaction_granted = request_transaction && (req_n >= v.gnt_dly);
            if (request_transaction) req_n++;
            busy_in = !is_rd && data_valid_out && (beat == v.stall_at) && (stall_n < v.stall_len);
            data_valid_in      = 1'b0;
            end_transaction_in = 1'b0;
            address_data_in    = '0;
            if (is_rd && begun && !end_sent) begin
                if (ret_n < v.n_ret) begin
                    data_valid_in   = ($urandom_range(0, 3) != 0);
                    address_data_in = word_of(v, ret_n);
                end else begin
                    end_transaction_in = 1'b1;
                    end_sent = 1;
                end
            end
            if (v.spur && begun && !spur_done) begin
                dma_data_ready = 1'b1;
                dma_readReady  = 1'b1;
                spur_done = 1;
            end
            #1;
            if (begin_transaction_out) begin
                chk({tag, "_begin_addr"}, address_data_out, v.addr);
                chk({tag, "_begin_be"}, byte_enables_out, v.be);
                chk({tag, "_begin_burst"}, burst_size_out, v.burst);
                chk({tag, "_begin_rnw"}, read_n_write_out, is_rd);
                begun = 1;
            end else if (!data_valid_out) begin
                chk({tag, "_bus_quiet"}, address_data_out, 0);
            end
            if (data_valid_out) begin
                chk({tag, "_wdata"}, address_data_out, word_of(v, beat));
                if (busy_in) stall_n++;
                else beat++;
            end
            if (buf_writeEnable) begin
                chk({tag, "_buf_addr"}, buf_address, wr_n);
                chk({tag, "_buf_data"}, buf_dataIn, word_of(v, wr_n));
                wr_n++;
            end
            if (data_valid_in) ret_n++;
            if (end_transaction_out) ended = 1;
            @(negedge clock);
            dma_data_ready = 1'b0;
            dma_readReady  = 1'b0;
            if ((is_rd && end_sent) || (!is_rd && ended)) break;
        end
        transaction_granted = 1'b0;
        busy_in             = 1'b0;
        data_valid_in       = 1'b0;
        end_transaction_in  = 1'b0;
        chk({tag, "_finished_in_time"}, cyc < 300, 1);
        chk({tag, "_count"}, is_rd ? wr_n : beat, v.exp_count);
        chk({tag, "_read_no_master_end"}, is_rd && ended, 0);
        chk({tag, "_idle_busy"}, dma_busy, 0);
        chk({tag, "_idle_swready"}, switch_ready, 1);
        chk({tag, "_idle_error"}, dma_error, 0);
        if (v.spur) begin
            repeat (2) begin
                @(negedge clock);
                chk({tag, "_spurious_ignored"}, dma_busy, 0);
            end
        end
    endtask

    task automatic err_seq();
        for (int i = 0; i < 4; i++) src_mem[i] = 32'h5000 + 32'(i);
        launch(32'h0000_1000, 8'd3, 1'b1, 1'b0);
        wait_grant_until_drive("err", 1'b0);
        error_in = 1'b1;
        @(negedge clock);
        error_in = 1'b0;
        chk("err_end_pulse", end_transaction_out, 1);
        chk("err_flag", dma_error, 1);
        chk("err_no_data", data_valid_out, 0);
        @(negedge clock);
        chk("err_back_idle", dma_busy, 0);
        chk("err_sticky", dma_error, 1);
        chk("err_single_pulse", end_transaction_out, 0);
    endtask

    task automatic timeout_seq();
        int n;
        src_mem[0] = 32'h7777;
        launch(32'h0000_2000, 8'd0, 1'b1, 1'b0);
        wait_grant_until_drive("tmo", 1'b0);
        busy_in = 1'b1;
        n = 0;
        while (!end_transaction_out && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("tmo_window", (n >= 250) && (n <= 260), 1);
        chk("tmo_error", dma_error, 1);
        busy_in = 1'b0;
        @(negedge clock);
        chk("tmo_idle", dma_busy, 0);
    endtask

    task automatic reset_seq();
        launch(32'h0000_3000, 8'd3, 1'b0, 1'b1);
        wait_grant_until_drive("rst", 1'b1);
        @(negedge clock);
        data_valid_in   = 1'b1;
        address_data_in = 32'hDEAD_BEEF;
        #1;
        chk("rst_pre_write", buf_writeEnable, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        data_valid_in   = 1'b0;
        address_data_in = '0;
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        for (int i = 0; i < 512; i++) src_mem[i] = '0;
        reset = 1'b1;
        dma_address = '0; dma_byte_enable = '0; dma_burst_size = '0;
        dma_data_ready = 1'b0; dma_readReady = 1'b0;
        transaction_granted = 1'b0; address_data_in = '0; data_valid_in = 1'b0;
        busy_in = 1'b0; end_transaction_in = 1'b0; error_in = 1'b0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h4000_0010, 4'hF, 8'd3, 2, -1, 0, 0, 32'hA0, 32'h1, 4};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'h3, 8'd3, 0, 1, 3, 0, 32'hA0, 32'h1, 4};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h2000_0000, 4'hF, 8'd1, 1, -1, 0, 2, 32'h11, 32'h11, 2};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h2000_0100, 4'hF, 8'd0, 0, -1, 0, 3, 32'h55, 32'h1, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h3000_0000, 4'hC, 8'd2, 0, -1, 0, 0, 32'hB0, 32'h1, 3};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h5000_0000, 4'hF, 8'd2, 1, 0, 2, 0, 32'hC0, 32'h10, 3};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h6000_0000, 4'h1, 8'd4, 3, -1, 0, 2, 32'h70, 32'h3, 2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h7000_0004, 4'h8, 8'd0, 0, 0, 1, 0, 32'hE0, 32'h1, 1};

        repeat (3) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        err_seq();
        run_vec(tbl[0], "post_err");
        timeout_seq();

        for (int i = 0; i < 24; i++) begin
            rv.rd        = 1'($urandom_range(0, 1));
            rv.both      = 1'b0;
            rv.spur      = 1'($urandom_range(0, 1));
            rv.addr      = $urandom;
            rv.be        = 4'($urandom_range(0, 15));
            rv.burst     = 8'($urandom_range(0, 9));
            rv.gnt_dly   = int'($urandom_range(0, 3));
            rv.stall_at  = int'($urandom_range(0, int'(rv.burst)));
            rv.stall_len = int'($urandom_range(0, 3));
            rv.n_ret     = int'($urandom_range(0, int'(rv.burst) + 3));
            rv.dbase     = $urandom;
            rv.dstep     = $urandom;
            rv.exp_count = rv.rd ? ((rv.n_ret < int'(rv.burst) + 1) ? rv.n_ret : int'(rv.burst) + 1)
                                 : int'(rv.burst) + 1;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        reset_seq();
        run_vec(tbl[2], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
